udp_tx_scheduler: RTL and testbench

UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

---
 rtl/udp_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_udp_tx_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: two-channel round-robin front end for a UDP sender.
// Grants one channel per packet, forwards its length/IP and muxes its FIFO.
module udp_tx_scheduler #(
   parameter logic [15:0] MIN_LEN = 16'd18,
   parameter logic [15:0] MAX_LEN = 16'd1472
) (
   input  logic        clk_156_25,
   input  logic        rst_n,
   input  logic [1:0]  ch_req,
   input  logic [15:0] ch0_len,
   input  logic [15:0] ch1_len,
   input  logic [31:0] ch0_ip_dst,
   input  logic [31:0] ch1_ip_dst,
   input  logic [63:0] ch0_rd_data,
   input  logic [63:0] ch1_rd_data,
   output logic [1:0]  ch_rd_req,
   output logic [1:0]  ch_done,
   output logic [1:0]  ch_err,
   output logic        tx_start,
   output logic [15:0] data_length,
   output logic [31:0] ip_dst_addr,
   input  logic        tx_idle,
   input  logic        rd_req,
   output logic [63:0] rd_data,
   output logic [15:0] pkt_cnt0,
   output logic [15:0] pkt_cnt1
);

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      ARB   = 5'b00010,
      START = 5'b00100,
      BUSY  = 5'b01000,
      DONE  = 5'b10000
   } state_t;

   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        last_q, last_d;
   logic [15:0] len_q, len_d;
   logic [31:0] ip_q, ip_d;
   logic        tx_start_q, tx_start_d;
   logic [1:0]  done_q, done_d;
   logic [1:0]  err_q, err_d;
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;

   logic        arb_sel;
   logic [15:0] arb_len;
   logic [31:0] arb_ip;
   logic        arb_ok;

   // When both channels ask, the one not served last wins.
   always_comb begin
      arb_sel = (ch_req == 2'b11) ? ~last_q : ch_req[1];
      arb_len = arb_sel ? ch1_len : ch0_len;
      arb_ip  = arb_sel ? ch1_ip_dst : ch0_ip_dst;
      arb_ok  = (arb_len >= MIN_LEN) && (arb_len <= MAX_LEN);
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      len_d      = len_q;
      ip_d       = ip_q;
      tx_start_d = 1'b0;
      done_d     = 2'b00;
      err_d      = 2'b00;
      cnt0_d     = cnt0_q;
      cnt1_d     = cnt1_q;
      unique case (state_q)
         IDLE: begin
            if (tx_idle && (ch_req != 2'b00)) state_d = ARB;
         end
         ARB: begin
            if (ch_req == 2'b00) begin
               state_d = IDLE;
            end else begin
               gnt_d = arb_sel;
               len_d = arb_len;
               ip_d  = arb_ip;
               if (arb_ok) begin
                  state_d    = START;
                  tx_start_d = 1'b1;
               end else begin
                  state_d         = IDLE;
                  err_d[arb_sel]  = 1'b1;
                  last_d          = arb_sel;
               end
            end
         end
         START: begin
            // Sender only leaves idle once the MAC is ready.
            if (!tx_idle) state_d = BUSY;
            else          tx_start_d = 1'b1;
         end
         BUSY: begin
            if (tx_idle) begin
               state_d      = DONE;
               done_d[gnt_q] = 1'b1;
               if (gnt_q) cnt1_d = cnt1_q + 16'd1;
               else       cnt0_d = cnt0_q + 16'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            last_d  = gnt_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_156_25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= 1'b0;
         last_q     <= 1'b1;
         len_q      <= 16'd0;
         ip_q       <= 32'd0;
         tx_start_q <= 1'b0;
         done_q     <= 2'b00;
         err_q      <= 2'b00;
         cnt0_q     <= 16'd0;
         cnt1_q     <= 16'd0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         len_q      <= len_d;
         ip_q       <= ip_d;
         tx_start_q <= tx_start_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
      end
   end

   always_comb begin
      ch_rd_req = 2'b00;
      if ((state_q == START) || (state_q == BUSY)) ch_rd_req[gnt_q] = rd_req;
   end

   assign rd_data     = gnt_q ? ch1_rd_data : ch0_rd_data;
   assign tx_start    = tx_start_q;
   assign data_length = len_q;
   assign ip_dst_addr = ip_q;
   assign ch_done     = done_q;
   assign ch_err      = err_q;
   assign pkt_cnt0    = cnt0_q;
   assign pkt_cnt1    = cnt1_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Bench for udp_tx_scheduler: directed scenarios, then random traffic
// checked against a packet-level model of grant order and counters.
`timescale 1ns/1ps
module tb_udp_tx_scheduler;

   logic        clk_156_25;
   logic        rst_n;
   logic [1:0]  ch_req;
   logic [15:0] ch0_len, ch1_len;
   logic [31:0] ch0_ip_dst, ch1_ip_dst;
   logic [63:0] ch0_rd_data, ch1_rd_data;
   logic [1:0]  ch_rd_req, ch_done, ch_err;
   logic        tx_start;
   logic [15:0] data_length;
   logic [31:0] ip_dst_addr;
   logic        tx_idle, rd_req;
   logic [63:0] rd_data;
   logic [15:0] pkt_cnt0, pkt_cnt1;

   int n_chk = 0;
   int n_fail = 0;
   int mac_wait, busy_len;
   logic snd_rnd;

   logic [1:0]  req_s;
   logic        last_m, cur_g, busy_m, prev_ts;
   logic [15:0] cnt_m0, cnt_m1;

   udp_tx_scheduler dut (
      .clk_156_25 (clk_156_25),
      .rst_n      (rst_n),
      .ch_req     (ch_req),
      .ch0_len    (ch0_len),
      .ch1_len    (ch1_len),
      .ch0_ip_dst (ch0_ip_dst),
      .ch1_ip_dst (ch1_ip_dst),
      .ch0_rd_data(ch0_rd_data),
      .ch1_rd_data(ch1_rd_data),
      .ch_rd_req  (ch_rd_req),
      .ch_done    (ch_done),
      .ch_err     (ch_err),
      .tx_start   (tx_start),
      .data_length(data_length),
      .ip_dst_addr(ip_dst_addr),
      .tx_idle    (tx_idle),
      .rd_req     (rd_req),
      .rd_data    (rd_data),
      .pkt_cnt0   (pkt_cnt0),
      .pkt_cnt1   (pkt_cnt1)
   );

   initial begin
      clk_156_25 = 1'b0;
      forever #3.2 clk_156_25 = ~clk_156_25;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic legal(input logic [15:0] l);
      return (l >= 16'd18) && (l <= 16'd1472);
   endfunction

   function automatic logic pick(input logic [1:0] r, input logic last);
      return (r == 2'b11) ? ~last : r[1];
   endfunction

   function automatic logic [15:0] rand_len();
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
         0: return 16'($urandom_range(0, 17));
         1: return 16'($urandom_range(1473, 3000));
         2: return 16'd18;
         3: return 16'd1472;
         4: return 16'd17;
         5: return 16'd1473;
         default: return 16'($urandom_range(18, 1472));
      endcase
   endfunction

   always @(posedge clk_156_25) req_s <= ch_req;

   // Sender: answers tx_start after a MAC wait, stays busy, then idles.
   initial begin
      int ph, cnt, mw, bl;
      tx_idle = 1'b1;
      ph = 0; cnt = 0; mw = 0; bl = 1;
      forever begin
         @(negedge clk_156_25);
         #1;
         if (!rst_n) begin
            tx_idle = 1'b1;
            ph = 0;
         end else begin
            case (ph)
               0: if (tx_start) begin
                  mw = snd_rnd ? int'($urandom_range(0, 4)) : mac_wait;
                  bl = snd_rnd ? int'($urandom_range(1, 6)) : busy_len;
                  if (mw == 0) begin
                     tx_idle = 1'b0; cnt = bl; ph = 2;
                  end else begin
                     cnt = mw; ph = 1;
                  end
               end
               1: begin
                  cnt--;
                  if (cnt == 0) begin
                     tx_idle = 1'b0; cnt = bl; ph = 2;
                  end
               end
               2: begin
                  cnt--;
                  if (cnt == 0) begin
                     tx_idle = 1'b1; ph = 0;
                  end
               end
               default: ph = 0;
            endcase
         end
      end
   end

   // Packet-level model: grant order, length legality, counters, FIFO mux.
   initial begin
      logic g;
      logic [15:0] gl;
      rd_req = 1'b0;
      ch0_rd_data = '0;
      ch1_rd_data = '0;
      last_m = 1'b1; busy_m = 1'b0; prev_ts = 1'b0; cur_g = 1'b0;
      cnt_m0 = '0; cnt_m1 = '0;
      forever begin
         @(negedge clk_156_25);
         if (!rst_n) begin
            last_m = 1'b1; busy_m = 1'b0; prev_ts = 1'b0;
            cnt_m0 = '0; cnt_m1 = '0;
         end else begin
            g  = pick(req_s, last_m);
            gl = g ? ch1_len : ch0_len;
            chk("done_err_excl", 64'((|ch_done) & (|ch_err)), 64'(0));
            if (tx_start && !prev_ts) begin
               chk("ts_once", 64'(busy_m), 64'(0));
               chk("ts_legal", 64'(legal(gl)), 64'(1));
               chk("ts_len", 64'(data_length), 64'(gl));
               chk("ts_ip", 64'(ip_dst_addr),
                   64'(g ? ch1_ip_dst : ch0_ip_dst));
               cur_g = g;
               busy_m = 1'b1;
            end
            if (|ch_err) begin
               chk("err_ch", 64'(ch_err), 64'(g ? 2'b10 : 2'b01));
               chk("err_len", 64'(legal(gl)), 64'(0));
               last_m = g;
            end
            if (busy_m && !(|ch_done)) begin
               chk("rd_req_mux", 64'(ch_rd_req),
                   64'(cur_g ? {rd_req, 1'b0} : {1'b0, rd_req}));
               chk("rd_data_mux", rd_data,
                   cur_g ? ch1_rd_data : ch0_rd_data);
            end else begin
               chk("rd_req_off", 64'(ch_rd_req), 64'(0));
            end
            if (|ch_done) begin
               chk("done_ch", 64'(ch_done), 64'(cur_g ? 2'b10 : 2'b01));
               chk("done_busy", 64'(busy_m), 64'(1));
               if (cur_g) cnt_m1 = cnt_m1 + 16'd1;
               else       cnt_m0 = cnt_m0 + 16'd1;
               chk("cnt0", 64'(pkt_cnt0), 64'(cnt_m0));
               chk("cnt1", 64'(pkt_cnt1), 64'(cnt_m1));
               last_m = cur_g;
               busy_m = 1'b0;
            end
            prev_ts = tx_start;
         end
         #1;
         rd_req = 1'($urandom);
         ch0_rd_data = {$urandom, $urandom};
         ch1_rd_data = {$urandom, $urandom};
      end
   end

   initial begin
      int t, n_e, n_t, n_hi;
      int gap[2], age[2];
      logic [1:0] nreq;
      logic [15:0] l0, l1;
      logic [31:0] i0, i1;
      rst_n = 1'b0; ch_req = 2'b00;
      ch0_len = '0; ch1_len = '0; ch0_ip_dst = '0; ch1_ip_dst = '0;
      snd_rnd = 1'b0; mac_wait = 1; busy_len = 3;
      repeat (3) @(negedge clk_156_25);
      chk("rst_ctl", 64'({tx_start, ch_rd_req, ch_done, ch_err}), 64'(0));
      chk("rst_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'(0));
      chk("rst_hdr", 64'({data_length, ip_dst_addr}), 64'(0));
      #1 rst_n = 1'b1;

      @(negedge clk_156_25);
      #1 ch0_len = 16'd100; ch0_ip_dst = 32'h0a00_0001; ch_req = 2'b01;
      @(negedge clk_156_25);
      chk("lat_arb", 64'(tx_start), 64'(0));
      @(negedge clk_156_25);
      chk("lat_start", 64'(tx_start), 64'(1));
      chk("len100", 64'(data_length), 64'(100));
      t = 0;
      while (tx_start && t < 50) begin @(negedge clk_156_25); t++; end
      chk("ts_hold", 64'(t), 64'(mac_wait + 1));
      #1 ch_req = 2'b00;
      t = 0;
      while (!(|ch_done) && t < 50) begin @(negedge clk_156_25); t++; end
      chk("drop_done0", 64'(ch_done), 64'(2'b01));
      chk("pkt0_one", 64'(pkt_cnt0), 64'(1));

      @(negedge clk_156_25);
      #1 mac_wait = 5; ch1_len = 16'd200; ch1_ip_dst = 32'h0a00_0002;
      ch_req = 2'b10;
      t = 0;
      while (!tx_start && t < 20) begin @(negedge clk_156_25); t++; end
      chk("ts_ch1", 64'(tx_start), 64'(1));
      n_hi = 0;
      while (tx_start && n_hi < 50) begin n_hi++; @(negedge clk_156_25); end
      chk("mac_hold", 64'(n_hi), 64'(6));
      t = 0;
      while (!(|ch_done) && t < 50) begin @(negedge clk_156_25); t++; end
      chk("done1", 64'(ch_done), 64'(2'b10));
      #1 ch_req = 2'b00; mac_wait = 1;

      for (int k = 0; k < 2; k++) begin
         @(negedge clk_156_25);
         #1 ch1_len = (k == 0) ? 16'd10 : 16'd1500; ch_req = 2'b10;
         n_e = 0; n_t = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk_156_25);
            if (ch_err[1]) n_e++;
            if (tx_start) n_t++;
            if (ch_err[1]) #1 ch_req = 2'b00;
         end
         chk("err_pulses", 64'(n_e), 64'(1));
         chk("err_no_ts", 64'(n_t), 64'(0));
      end
      chk("err_cnt1", 64'(pkt_cnt1), 64'(1));

      @(negedge clk_156_25);
      #1 ch0_len = 16'd64; ch1_len = 16'd128; ch_req = 2'b11;
      for (int p = 0; p < 4; p++) begin
         t = 0;
         while (!(|ch_done) && t < 60) begin @(negedge clk_156_25); t++; end
         chk("rr_order", 64'(ch_done), 64'(p[0] ? 2'b10 : 2'b01));
         @(negedge clk_156_25);
      end
      #1 ch_req = 2'b00;
      chk("rr_cnt0", 64'(pkt_cnt0), 64'(3));
      chk("rr_cnt1", 64'(pkt_cnt1), 64'(3));

      @(negedge clk_156_25);
      #1 busy_len = 20; ch_req = 2'b10;
      t = 0;
      while (tx_idle && t < 30) begin @(negedge clk_156_25); t++; end
      chk("busy_reached", 64'(tx_idle), 64'(0));
      repeat (3) @(negedge clk_156_25);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_ctl", 64'({tx_start, ch_rd_req, ch_done, ch_err}), 64'(0));
      chk("rst_async_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'(0));
      chk("rst_async_hdr", 64'({data_length, ip_dst_addr}), 64'(0));
      ch0_len = 16'd300; ch1_len = 16'd400; ch_req = 2'b11; busy_len = 2;
      repeat (2) @(negedge clk_156_25);
      chk("rst_no_done", 64'(ch_done), 64'(0));
      #1 rst_n = 1'b1;
      t = 0;
      while (!tx_start && t < 20) begin @(negedge clk_156_25); t++; end
      chk("post_rst_gnt", 64'(data_length), 64'(300));
      t = 0;
      while (!(|ch_done) && t < 50) begin @(negedge clk_156_25); t++; end
      chk("post_rst_done", 64'(ch_done), 64'(2'b01));
      #1 ch_req = 2'b00;

      snd_rnd = 1'b1;
      gap[0] = 1; gap[1] = 2; age[0] = 0; age[1] = 0;
      l0 = ch0_len; l1 = ch1_len; i0 = ch0_ip_dst; i1 = ch1_ip_dst;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(negedge clk_156_25);
         nreq = ch_req;
         for (int c = 0; c < 2; c++) begin
            if (ch_req[c]) begin
               if (ch_done[c] || ch_err[c]) begin
                  nreq[c] = 1'b0;
                  gap[c] = int'($urandom_range(1, 4));
                  age[c] = 0;
               end else begin
                  age[c]++;
                  if (age[c] == 400) chk("req_served", 64'(age[c]), 64'(0));
               end
            end else if (cyc < 5000) begin
               if (gap[c] > 0) begin
                  gap[c]--;
               end else begin
                  nreq[c] = 1'b1;
                  if (c == 0) begin l0 = rand_len(); i0 = $urandom; end
                  else        begin l1 = rand_len(); i1 = $urandom; end
               end
            end
         end
         #1;
         ch0_len = l0; ch1_len = l1; ch0_ip_dst = i0; ch1_ip_dst = i1;
         ch_req = nreq;
      end
      chk("drained", 64'(ch_req), 64'(0));
      chk("final_cnt0", 64'(pkt_cnt0), 64'(cnt_m0));
      chk("final_cnt1", 64'(pkt_cnt1), 64'(cnt_m1));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
